// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared SRAM FIFO defaults, reader state encoding and read latency
package sram_fifo_pkg;
  localparam int BITS     = 8;
  localparam int DEPTH    = 8;
  localparam int READ_LAT = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
endpackage

// File: rtl/sram_fifo_skid.sv
// sram_fifo_skid: two-entry skid buffer reporting free space including in-flight reservations
module sram_fifo_skid
  import sram_fifo_pkg::*;
#(
  parameter int bits = BITS
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [bits-1:0] data_i,
  input  logic            pop_i,
  input  logic            issue_i,
  output logic [bits-1:0] data_o,
  output logic            valid_o,
  output logic [1:0]      space_o,
  output logic            stall_o
);
  logic [bits-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [1:0]      lvl_q, lvl_d, lvl_pop;
  // Shift the head on pop, then land a push in the first free slot
  always_comb begin
    lvl_pop = lvl_q - 2'(pop_i);
    h0_d    = (push_i && lvl_pop == 2'd0) ? data_i : pop_i ? h1_q : h0_q;
    h1_d    = (push_i && lvl_pop == 2'd1) ? data_i : h1_q;
    lvl_d   = lvl_pop + 2'(push_i);
  end
  // Storage and fill level; reset empties the buffer and clears the head
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      h0_q  <= '0;
      h1_q  <= '0;
      lvl_q <= '0;
    end else begin
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      lvl_q <= lvl_d;
    end
  end
  assign data_o  = h0_q;
  assign valid_o = lvl_q != 2'd0;
  // push_i doubles as the in-flight marker; a pop this cycle frees a slot in time for a new read
  assign space_o = 2'd2 - lvl_q - 2'(push_i) + 2'(pop_i);
  assign stall_o = ({1'b0, lvl_d} + 3'(issue_i)) >= 3'd2;
endmodule

// File: rtl/sram_fifo_reader.sv
// sram_fifo_reader: read-side controller for SRAM_fifo with shadow occupancy and valid/ready output
// Optional SRAM_FIFO_READER_STATS_EN adds a 16-bit wrapping count of delivered packets.
module sram_fifo_reader
  import sram_fifo_pkg::*;
#(
  parameter int bits    = BITS,
  parameter int depth   = DEPTH,
  parameter int cntBits = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               writeMode,
  output logic               readMode,
  input  logic [bits-1:0]    fifoPacket,
  output logic [bits-1:0]    outData,
  output logic               outValid,
  input  logic               outReady,
  output logic [cntBits-1:0] count,
  output logic               overflow
`ifdef SRAM_FIFO_READER_STATS_EN
  ,
  output logic [15:0]        delivered
`endif
);
  state_e              state_q, state_d;
  logic [cntBits-1:0]  count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [READ_LAT-1:0] fly_q;
  logic                push, pop, stall;
  logic [1:0]          space;

  assign push     = fly_q[READ_LAT-1];
  assign pop      = outValid && outReady;
  assign readMode = state_q != IDLE && count_q != '0 && space != 2'd0;
  assign count    = count_q;
  assign overflow = ovf_q;

  sram_fifo_skid #(.bits(bits)) u_skid (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (fifoPacket),
    .pop_i   (pop),
    .issue_i (readMode),
    .data_o  (outData),
    .valid_o (outValid),
    .space_o (space),
    .stall_o (stall)
  );

  // Shadow count, sticky overflow, and next state; WAIT means no credit remains without a handshake
  always_comb begin
    count_d = count_q + cntBits'(writeMode && count_q < cntBits'(depth)) - cntBits'(readMode);
    ovf_d   = ovf_q || (writeMode && count_q == cntBits'(depth));
    state_d = count_d == '0 ? IDLE : stall ? WAIT : ISSUE;
  end

  // Controller state and read-latency pipeline; reset drops any packet still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      fly_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      fly_q   <= READ_LAT'({fly_q, readMode});
    end
  end

`ifdef SRAM_FIFO_READER_STATS_EN
  logic [15:0] delivered_q;
  // Handshake counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) delivered_q <= '0;
    else      delivered_q <= delivered_q + 16'(pop);
  end
  assign delivered = delivered_q;
`endif
endmodule
